access_check_ctrl: RTL and testbench
====================================

# access_check_ctrl

Controller that sequences the ID-check datapath behind the AXI-lite register wrapper. It accepts the fixed ID written by software and scans a small table of authorised IDs, one entry per clock. It drives the access_granted, access_denied and irq_flag status bits that the wrapper exposes to software. After repeated denials it enforces a timed lockout.

## Interface
- N_ENTRIES, 8: number of authorised-ID table entries (power of 2, 2..64)
- ID_W, 32: ID width
- LOCK_THRESH, 3: consecutive denials that trigger lockout (≥1)
- LOCK_CYCLES, 1000: lockout duration in clocks (≥2)

- S_AXI_ACLK  in  1  clock
- S_AXI_ARESET  in  1  synchronous active-high reset
- id_in  in  ID_W  ID to check; sampled only on accepted id_valid
- id_valid  in  1  one-cycle request to start a check
- tbl_we  in  1  table write strobe
- tbl_addr  in  log2(N_ENTRIES)  table index
- tbl_data  in  ID_W  authorised ID
- tbl_en  in  1  entry valid bit written alongside tbl_data
- irq_clear  in  1  clears irq_flag
- access_granted  out  1  last check matched (level)
- access_denied  out  1  last check failed (level)
- irq_flag  out  1  sticky completion interrupt
- busy  out  1  check in progress (SCAN)
- locked  out  1  lockout active

## Operation
- Table: N_ENTRIES × {valid, ID_W}, register array. Reset clears all valid bits. Writes are accepted in every state.
- FSM states: IDLE, SCAN, LOCKOUT.
- IDLE:
  - On id_valid, latch id_in, clear access_granted/access_denied, set idx=0, go to SCAN.
- SCAN:
  - Each cycle compare entry[idx] (valid && data==latched ID).
  - On a match: set access_granted, set irq_flag, clear fail_cnt, go to IDLE.
  - On a miss with idx==N_ENTRIES-1: set access_denied, set irq_flag, fail_cnt+1 (saturating at LOCK_THRESH).
    - If the new fail_cnt == LOCK_THRESH, load lock_cnt=LOCK_CYCLES-1 and go to LOCKOUT.
    - Otherwise go to IDLE.
  - Otherwise idx+1.
- LOCKOUT:
  - lock_cnt decrements each cycle.
  - At 0: clear fail_cnt, go to IDLE.
  - access_denied remains high throughout.
- id_valid outside IDLE is ignored (dropped, not queued).
- Result bits are levels. Exactly one of the two is high after a completed check. Both are low during SCAN and after reset.
- irq_flag:
  - Set on every completed check.
  - Cleared by irq_clear in IDLE/LOCKOUT/SCAN.
  - Set wins over a simultaneous irq_clear.
- Duplicate table IDs: the first matching index terminates the scan; the result is identical either way.
- Entry with valid=0 never matches, including ID 0.

## Timing
- Reset: state IDLE, all outputs 0, fail_cnt=0, lock_cnt=0, table valid bits 0.
- id_valid accepted at edge T → busy=1 from T+1.
- Entry i is compared in cycle T+1+i.
- Match at entry i → access_granted=1, irq_flag=1, busy=0 from T+2+i. Best case 2 cycles.
- No match → access_denied=1 from T+1+N_ENTRIES.
- The cycle after a result is IDLE; a new id_valid there is accepted.
- Lockout: locked=1 for exactly LOCK_CYCLES cycles, starting the same cycle access_denied rises. The first accepted id_valid after lockout is in the cycle locked falls.
- Table write and compare of the same index in the same cycle: the compare uses the old value; the new value is visible the next cycle.
- Reset mid-SCAN or mid-LOCKOUT: immediate return to reset values. No result or irq is produced.
- Counter widths:
  - idx = log2(N_ENTRIES).
  - fail_cnt = clog2(LOCK_THRESH+1).
  - lock_cnt = clog2(LOCK_CYCLES).
  - No wrap: fail_cnt saturates and lock_cnt stops at 0.

## Structure
- Shared package access_pkg:
  - FSM state enum (IDLE, SCAN, LOCKOUT).
  - Status bit positions {irq_flag=2, access_denied=1, access_granted=0} used by the register wrapper's status read.
  - Default ID_W.
- One sub-module, access_id_table: register array with write port, a single combinational read port by index, and clear-on-reset.
- FSM, counters and flags live in access_check_ctrl.

## Test plan
- Table entry 3 = {1, 0xCAFE0001}; id_valid with 0xCAFE0001 at T → access_granted=1, irq_flag=1, busy=0 at T+5; access_denied=0.
- Empty table; id 0x12345678 → access_denied=1 at T+9 (N=8). irq_clear at T+12 → irq_flag=0 at T+13. Entry with valid=0 and data 0 never matches ID 0.
- Three consecutive misses → locked=1 for exactly 1000 cycles. id_valid mid-lockout is ignored. After lockout a valid ID is granted and fail_cnt reads 0 (two subsequent misses don't lock).
- Entry 5 rewritten from 0xA to 0xB in the same cycle entry 5 is compared for ID 0xB → miss (denied). The next check of 0xB is granted.
- irq_clear coincident with result completion → irq_flag=1. Reset asserted mid-SCAN → all outputs 0 next cycle, no irq, table valid bits cleared.
- id_valid pulsed every cycle against a hit at entry 0 → one check every 2 cycles. Intermediate pulses are dropped and access_granted toggles 0/1 accordingly.

Source files
------------

// File: rtl/access_pkg.sv
// Shared definitions for the ID-check controller and its AXI-lite register wrapper.
package access_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StLockout
    } access_state_e;

    // Status word bit positions seen by software through the wrapper.
    localparam int unsigned STAT_GRANTED_BIT = 0;
    localparam int unsigned STAT_DENIED_BIT  = 1;
    localparam int unsigned STAT_IRQ_BIT     = 2;
    localparam int unsigned STAT_W           = 3;

    localparam int unsigned ACCESS_ID_W = 32;

endpackage

// File: rtl/access_id_table.sv
// Authorised-ID table: register array with one write port and one combinational read port.
module access_id_table
    import access_pkg::*;
#(
    parameter int unsigned N_ENTRIES = 8,
    parameter int unsigned ID_W      = ACCESS_ID_W
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         we_i,
    input  logic [$clog2(N_ENTRIES)-1:0] waddr_i,
    input  logic [ID_W-1:0]              wdata_i,
    input  logic                         wen_i,
    input  logic [$clog2(N_ENTRIES)-1:0] raddr_i,
    output logic                         rvalid_o,
    output logic [ID_W-1:0]              rdata_o
);

    logic [N_ENTRIES-1:0] valid_q;
    logic [ID_W-1:0]      data_q [N_ENTRIES];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[waddr_i] <= wen_i;
        end
    end

    // Data needs no reset: an entry is only ever consulted through its valid bit.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            data_q[waddr_i] <= wdata_i;
        end
    end

    assign rvalid_o = valid_q[raddr_i];
    assign rdata_o  = data_q[raddr_i];

endmodule

// File: rtl/access_check_ctrl.sv
// ID-check controller: scans the authorised-ID table one entry per clock and enforces a
// timed lockout after repeated denials.
module access_check_ctrl
    import access_pkg::*;
#(
    parameter int unsigned N_ENTRIES   = 8,
    parameter int unsigned ID_W        = ACCESS_ID_W,
    parameter int unsigned LOCK_THRESH = 3,
    parameter int unsigned LOCK_CYCLES = 1000
) (
    input  logic                         S_AXI_ACLK,
    input  logic                         S_AXI_ARESET,
    input  logic [ID_W-1:0]              id_in,
    input  logic                         id_valid,
    input  logic                         tbl_we,
    input  logic [$clog2(N_ENTRIES)-1:0] tbl_addr,
    input  logic [ID_W-1:0]              tbl_data,
    input  logic                         tbl_en,
    input  logic                         irq_clear,
    output logic                         access_granted,
    output logic                         access_denied,
    output logic                         irq_flag,
    output logic                         busy,
    output logic                         locked
);

    localparam int unsigned IDX_W = $clog2(N_ENTRIES);
    localparam int unsigned FAIL_W = $clog2(LOCK_THRESH + 1);
    localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES);

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_ENTRIES - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(LOCK_THRESH);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCK_CYCLES - 1);

    access_state_e       state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [FAIL_W-1:0]   fail_cnt_q, fail_cnt_d, fail_inc;
    logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [STAT_W-1:0]   status_q, status_d;

    logic                entry_valid;
    logic [ID_W-1:0]     entry_data;
    logic                entry_hit;

    access_id_table #(
        .N_ENTRIES (N_ENTRIES),
        .ID_W      (ID_W)
    ) u_table (
        .clk_i    (S_AXI_ACLK),
        .rst_i    (S_AXI_ARESET),
        .we_i     (tbl_we),
        .waddr_i  (tbl_addr),
        .wdata_i  (tbl_data),
        .wen_i    (tbl_en),
        .raddr_i  (idx_q),
        .rvalid_o (entry_valid),
        .rdata_o  (entry_data)
    );

    assign entry_hit = entry_valid && (entry_data == id_q);
    assign fail_inc  = (fail_cnt_q == FAIL_MAX) ? fail_cnt_q : fail_cnt_q + FAIL_W'(1);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        id_d       = id_q;
        fail_cnt_d = fail_cnt_q;
        lock_cnt_d = lock_cnt_q;
        status_d   = status_q;

        // Clear first so that a completion in the same cycle re-sets the flag.
        if (irq_clear) begin
            status_d[STAT_IRQ_BIT] = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (id_valid) begin
                    id_d                       = id_in;
                    idx_d                      = '0;
                    status_d[STAT_GRANTED_BIT] = 1'b0;
                    status_d[STAT_DENIED_BIT]  = 1'b0;
                    state_d                    = StScan;
                end
            end
            StScan: begin
                if (entry_hit) begin
                    status_d[STAT_GRANTED_BIT] = 1'b1;
                    status_d[STAT_IRQ_BIT]     = 1'b1;
                    fail_cnt_d                 = '0;
                    state_d                    = StIdle;
                end else if (idx_q == IDX_LAST) begin
                    status_d[STAT_DENIED_BIT] = 1'b1;
                    status_d[STAT_IRQ_BIT]    = 1'b1;
                    fail_cnt_d                = fail_inc;
                    if (fail_inc == FAIL_MAX) begin
                        lock_cnt_d = LOCK_LOAD;
                        state_d    = StLockout;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            StLockout: begin
                if (lock_cnt_q == '0) begin
                    fail_cnt_d = '0;
                    state_d    = StIdle;
                end else begin
                    lock_cnt_d = lock_cnt_q - LOCK_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            id_q       <= '0;
            fail_cnt_q <= '0;
            lock_cnt_q <= '0;
            status_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            id_q       <= id_d;
            fail_cnt_q <= fail_cnt_d;
            lock_cnt_q <= lock_cnt_d;
            status_q   <= status_d;
        end
    end

    assign access_granted = status_q[STAT_GRANTED_BIT];
    assign access_denied  = status_q[STAT_DENIED_BIT];
    assign irq_flag       = status_q[STAT_IRQ_BIT];
    assign busy           = (state_q == StScan);
    assign locked         = (state_q == StLockout);

endmodule

// File: tb/tb_access_check_ctrl.sv
// Directed self-checking bench for access_check_ctrl (N_ENTRIES=8, LOCK_THRESH=3, LOCK_CYCLES=1000).
module tb_access_check_ctrl;

    localparam int unsigned N  = 8;
    localparam int unsigned IW = 32;
    localparam int unsigned LC = 1000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [IW-1:0] id_in = '0;
    logic          id_valid = 1'b0;
    logic          tbl_we = 1'b0;
    logic [2:0]    tbl_addr = '0;
    logic [IW-1:0] tbl_data = '0;
    logic          tbl_en = 1'b0;
    logic          irq_clear = 1'b0;
    logic          granted, denied, irq, busy, locked;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    access_check_ctrl #(
        .N_ENTRIES   (N),
        .ID_W        (IW),
        .LOCK_THRESH (3),
        .LOCK_CYCLES (LC)
    ) dut (
        .S_AXI_ACLK     (clk),
        .S_AXI_ARESET   (rst),
        .id_in          (id_in),
        .id_valid       (id_valid),
        .tbl_we         (tbl_we),
        .tbl_addr       (tbl_addr),
        .tbl_data       (tbl_data),
        .tbl_en         (tbl_en),
        .irq_clear      (irq_clear),
        .access_granted (granted),
        .access_denied  (denied),
        .irq_flag       (irq),
        .busy           (busy),
        .locked         (locked)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic write_entry(input logic [2:0] a, input logic [IW-1:0] d, input logic en);
        tbl_we = 1'b1; tbl_addr = a; tbl_data = d; tbl_en = en;
        tick();
        tbl_we = 1'b0;
    endtask

    // Returns just after the accepting edge.
    task automatic start(input logic [IW-1:0] id);
        id_valid = 1'b1; id_in = id;
        tick();
        id_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout: busy=%b required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (granted !== 1'b0) begin errors++; $display("FAIL rst_granted: %b req 0", granted); end
        checks++; if (denied !== 1'b0) begin errors++; $display("FAIL rst_denied: %b req 0", denied); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: %b req 0", irq); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: %b req 0", busy); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked: %b req 0", locked); end
    endtask

    task automatic test_grant();
        do_reset();
        write_entry(3'd3, 32'hCAFE0001, 1'b1);
        start(32'hCAFE0001);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL grant_busy: %b req 1", busy); end
        repeat (3) tick();
        checks++; if (granted !== 1'b0) begin errors++; $display("FAIL grant_early: %b req 0", granted); end
        tick();
        checks++; if (granted !== 1'b1) begin errors++; $display("FAIL grant_lat: %b req 1", granted); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL grant_irq: %b req 1", irq); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL grant_busy_end: %b req 0", busy); end
        checks++; if (denied !== 1'b0) begin errors++; $display("FAIL grant_denied: %b req 0", denied); end
    endtask

    task automatic test_deny();
        do_reset();
        start(32'h12345678);
        repeat (7) tick();
        checks++; if (denied !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL deny_early: denied=%b busy=%b req 0/1", denied, busy);
        end
        tick();
        checks++; if (denied !== 1'b1) begin errors++; $display("FAIL deny_lat: %b req 1", denied); end
        checks++; if (granted !== 1'b0) begin errors++; $display("FAIL deny_granted: %b req 0", granted); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL deny_irq: %b req 1", irq); end
        tick(); tick();
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL deny_irq_clear: %b req 0", irq); end
        write_entry(3'd2, 32'h0, 1'b0);
        start(32'h0);
        wait_done("deny_zero");
        checks++; if (granted !== 1'b0 || denied !== 1'b1) begin
            errors++; $display("FAIL deny_zero_id: granted=%b denied=%b req 0/1", granted, denied);
        end
    endtask

    task automatic test_lockout();
        int cnt;
        int low_denied;
        do_reset();
        write_entry(3'd0, 32'h55, 1'b1);
        for (int k = 0; k < 3; k++) begin
            start(32'h99);
            wait_done("lock_miss");
        end
        checks++; if (locked !== 1'b1 || denied !== 1'b1) begin
            errors++; $display("FAIL lock_start: locked=%b denied=%b req 1/1", locked, denied);
        end
        cnt = 1;
        low_denied = 0;
        while (locked === 1'b1 && cnt < 2000) begin
            if (cnt == 500) begin
                id_valid = 1'b1; id_in = 32'h55;
            end
            tick();
            id_valid = 1'b0;
            if (locked === 1'b1) begin
                cnt++;
                if (denied !== 1'b1) low_denied++;
            end
        end
        checks++; if (cnt != LC) begin errors++; $display("FAIL lock_len: %0d req %0d", cnt, LC); end
        checks++; if (low_denied != 0) begin
            errors++; $display("FAIL lock_denied_level: %0d low cycles req 0", low_denied);
        end
        checks++; if (granted !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL lock_ignored_req: granted=%b busy=%b req 0/0", granted, busy);
        end
        start(32'h55);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lock_accept: busy=%b req 1", busy); end
        wait_done("lock_grant");
        checks++; if (granted !== 1'b1) begin errors++; $display("FAIL lock_grant: %b req 1", granted); end
        for (int k = 0; k < 2; k++) begin
            start(32'h98);
            wait_done("lock_post_miss");
        end
        checks++; if (locked !== 1'b0 || denied !== 1'b1) begin
            errors++; $display("FAIL lock_fail_cnt: locked=%b denied=%b req 0/1", locked, denied);
        end
    endtask

    task automatic test_same_cycle_write();
        do_reset();
        write_entry(3'd5, 32'hA, 1'b1);
        start(32'hB);
        repeat (5) tick();
        tbl_we = 1'b1; tbl_addr = 3'd5; tbl_data = 32'hB; tbl_en = 1'b1;
        tick();
        tbl_we = 1'b0;
        wait_done("wr_first");
        checks++; if (denied !== 1'b1 || granted !== 1'b0) begin
            errors++; $display("FAIL wr_old_value: granted=%b denied=%b req 0/1", granted, denied);
        end
        start(32'hB);
        wait_done("wr_second");
        checks++; if (granted !== 1'b1) begin errors++; $display("FAIL wr_new_value: %b req 1", granted); end
    endtask

    task automatic test_irq_and_reset();
        do_reset();
        write_entry(3'd0, 32'h77, 1'b1);
        start(32'h77);
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        checks++; if (irq !== 1'b1 || granted !== 1'b1) begin
            errors++; $display("FAIL irq_set_wins: irq=%b granted=%b req 1/1", irq, granted);
        end
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        write_entry(3'd7, 32'h33, 1'b1);
        start(32'h33);
        tick(); tick();
        rst = 1'b1;
        tick();
        checks++; if ({granted, denied, irq, busy, locked} !== 5'b0) begin
            errors++; $display("FAIL rst_mid_scan: %b req 00000", {granted, denied, irq, busy, locked});
        end
        rst = 1'b0;
        repeat (8) tick();
        checks++; if (irq !== 1'b0 || granted !== 1'b0) begin
            errors++; $display("FAIL rst_no_result: irq=%b granted=%b req 0/0", irq, granted);
        end
        start(32'h33);
        wait_done("rst_tbl");
        checks++; if (denied !== 1'b1 || granted !== 1'b0) begin
            errors++; $display("FAIL rst_tbl_cleared: granted=%b denied=%b req 0/1", granted, denied);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        write_entry(3'd0, 32'h42, 1'b1);
        id_valid = 1'b1; id_in = 32'h42;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (granted !== ((k % 2) == 0) || busy !== ((k % 2) == 1)) begin
                errors++;
                $display("FAIL b2b_edge%0d: granted=%b busy=%b req %b/%b", k, granted, busy,
                         (k % 2) == 0, (k % 2) == 1);
            end
        end
        id_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_grant();
        test_deny();
        test_lockout();
        test_same_cycle_write();
        test_irq_and_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
